cyc_delay_line: RTL

Parametrised multi-channel cycle-delay line: each channel delays a valid-qualified data word by a runtime-programmable number of clock cycles (the synthesizable counterpart of a `##N` clocking-block drive). It sits between stimulus/control logic and downstream registered consumers such as the flip-flop and inverter models. It generalises a fixed single-width delay to N channels with per-channel programmable depth, flush, and a hold/zero idle mode.

---
 rtl/cyc_delay_line_if.sv | 31 +++
 rtl/cyc_delay_line.sv | 90 +++++++++
 2 files changed

// File: rtl/cyc_delay_line_if.sv
// Channel-bundled handshake/data signals for cyc_delay_line.
// The master side drives samples and configuration; the slave side returns delayed samples.
interface cyc_delay_line_if #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 2,
    parameter int MAX_DELAY = 8
);
    localparam int DW = $clog2(MAX_DELAY + 1);

    // in_valid qualifies in_data per channel; it is a strobe, not a handshake:
    // there is no ready, and every valid sample is emitted exactly once
    // unless it is dropped by flush, reconfiguration or reset.
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS*DW-1:0]    delay_cfg;
    logic [CHANNELS-1:0]       cfg_load;
    logic [CHANNELS-1:0]       flush;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       busy;

    modport master (
        output in_valid, in_data, delay_cfg, cfg_load, flush,
        input  out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, delay_cfg, cfg_load, flush,
        output out_valid, out_data, busy
    );
endinterface

// File: rtl/cyc_delay_line.sv
// Multi-channel valid-qualified delay line with per-channel programmable depth,
// flush, and hold-or-zero idle output.
module cyc_delay_line #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 2,
    parameter int MAX_DELAY = 8,
    parameter int HOLD      = 1
) (
    input logic            clk,
    input logic            rst_n,
    cyc_delay_line_if.slave bus
);
    localparam int DW = $clog2(MAX_DELAY + 1);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DW-1:0]        cfg_field;
        logic [DW-1:0]        cfg_clamped;
        logic [DW-1:0]        dly_q, dly_d;
        logic [MAX_DELAY-1:0] vld_q, vld_d;
        logic [WIDTH-1:0]     data_q [MAX_DELAY];
        logic [WIDTH-1:0]     hold_q, hold_d;
        logic                 drop;
        logic                 sel_vld;
        logic [WIDTH-1:0]     sel_data;
        logic                 busy_c;

        assign cfg_field = bus.delay_cfg[c*DW +: DW];

        always_comb begin
            cfg_clamped = cfg_field;
            if (cfg_field == '0)
                cfg_clamped = DW'(1);
            else if (cfg_field > DW'(MAX_DELAY))
                cfg_clamped = DW'(MAX_DELAY);
        end

        // A depth change invalidates everything already past stage 0 so no
        // old sample can emerge at the wrong latency.
        always_comb begin
            dly_d = dly_q;
            drop  = bus.flush[c];
            if (bus.cfg_load[c]) begin
                dly_d = cfg_clamped;
                if (cfg_clamped != dly_q)
                    drop = 1'b1;
            end
            vld_d    = '0;
            vld_d[0] = bus.in_valid[c];
            for (int k = 1; k < MAX_DELAY; k++)
                vld_d[k] = drop ? 1'b0 : vld_q[k-1];
        end

        always_comb begin
            sel_vld  = 1'b0;
            sel_data = '0;
            busy_c   = 1'b0;
            for (int k = 0; k < MAX_DELAY; k++) begin
                if (dly_q == DW'(k + 1)) begin
                    sel_vld  = vld_q[k];
                    sel_data = data_q[k];
                end
                if (DW'(k) < dly_q)
                    busy_c = busy_c | vld_q[k];
            end
            hold_d = sel_vld ? sel_data : hold_q;
        end

        assign bus.out_valid[c]              = sel_vld;
        assign bus.out_data[c*WIDTH +: WIDTH] = sel_vld ? sel_data :
                                               ((HOLD != 0) ? hold_q : '0);
        assign bus.busy[c]                   = busy_c;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= '0;
                dly_q  <= DW'(MAX_DELAY);
                hold_q <= '0;
                for (int k = 0; k < MAX_DELAY; k++)
                    data_q[k] <= '0;
            end else begin
                vld_q     <= vld_d;
                dly_q     <= dly_d;
                hold_q    <= hold_d;
                data_q[0] <= bus.in_data[c*WIDTH +: WIDTH];
                for (int k = 1; k < MAX_DELAY; k++)
                    data_q[k] <= data_q[k-1];
            end
        end
    end
endmodule
